// File: rtl/alu_req_scheduler.sv
// alu_req_scheduler: shares one 8-bit arithmetic unit among NREQ requesters.
// A round-robin arbiter grants one request at a time. The block executes it
// and returns the result tagged with the owning requester's index.
// Optional feature macro: ALU_REQ_SCHEDULER_DIVZ_EN. When it is defined,
// divide-by-zero returns 8'hFF with o_resp_err set. When it is undefined,
// divide-by-zero returns 8'h00 and o_resp_err is always 0.
module alu_req_scheduler #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      i_req_valid,
  output logic [NREQ-1:0]      o_req_ready,
  input  logic [2*NREQ-1:0]    i_req_op,
  input  logic [3*NREQ-1:0]    i_req_a,
  input  logic [3*NREQ-1:0]    i_req_b,
  output logic                 o_resp_valid,
  input  logic                 i_resp_ready,
  output logic [7:0]           o_resp_data,
  output logic [ID_W-1:0]      o_resp_id,
  output logic                 o_resp_err,
  output logic                 o_busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t          r_state;
  logic [ID_W-1:0] r_last_grant;
  logic [ID_W-1:0] r_gnt_id;
  logic [1:0]      r_op;
  logic [2:0]      r_a;
  logic [2:0]      r_b;
  logic [7:0]      r_resp_data;
  logic [ID_W-1:0] r_resp_id;
  logic            r_resp_err;
  logic            r_resp_valid;
  logic            r_busy;

  // Per-requester unpacked view of the packed request buses.
  logic [1:0]      w_req_op   [NREQ];
  logic [2:0]      w_req_a    [NREQ];
  logic [2:0]      w_req_b    [NREQ];
  // Rotation distance of each requester from the slot after the last grant.
  // Distance 0 has the highest priority.
  logic [7:0]      w_dist     [NREQ];

  logic            w_grant_any;
  logic [ID_W-1:0] w_grant_idx;
  logic [1:0]      w_grant_op;
  logic [2:0]      w_grant_a;
  logic [2:0]      w_grant_b;
  logic [7:0]      w_best;

  logic [7:0]      w_a8;
  logic [7:0]      w_b8;
  logic [7:0]      w_result;
  logic            w_err;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      assign w_req_op[gi] = i_req_op[2*gi +: 2];
      assign w_req_a[gi]  = i_req_a[3*gi +: 3];
      assign w_req_b[gi]  = i_req_b[3*gi +: 3];
      // r_last_grant never exceeds NREQ-1, so the subtraction cannot go negative.
      assign w_dist[gi]   = 8'((gi + NREQ - 1 - int'(r_last_grant)) % NREQ);
      // The handshake is only offered while idle, and only to the arbitration winner.
      assign o_req_ready[gi] = (r_state == IDLE) && w_grant_any &&
                               (w_grant_idx == ID_W'(gi));
    end
  endgenerate

  // Round-robin arbitration: the valid requester closest after last_grant wins.
  always_comb begin
    w_grant_any = 1'b0;
    w_grant_idx = '0;
    w_grant_op  = '0;
    w_grant_a   = '0;
    w_grant_b   = '0;
    w_best      = 8'hFF;
    for (int i = 0; i < NREQ; i++) begin
      if (i_req_valid[i] && (w_dist[i] < w_best)) begin
        w_best      = w_dist[i];
        w_grant_any = 1'b1;
        w_grant_idx = ID_W'(i);
        w_grant_op  = w_req_op[i];
        w_grant_a   = w_req_a[i];
        w_grant_b   = w_req_b[i];
      end
    end
  end

  // Shared arithmetic unit, operating on the captured zero-extended operands.
  always_comb begin
    w_a8     = {5'b0, r_a};
    w_b8     = {5'b0, r_b};
    w_result = 8'h00;
    w_err    = 1'b0;
    case (r_op)
      2'b00: w_result = w_a8 + w_b8;
      2'b01: w_result = w_a8 - w_b8;
      2'b10: w_result = w_a8 * w_b8;
      default: begin
        if (r_b == 3'd0) begin
`ifdef ALU_REQ_SCHEDULER_DIVZ_EN
          w_result = 8'hFF;
          w_err    = 1'b1;
`else
          w_result = 8'h00;
          w_err    = 1'b0;
`endif
        end else begin
          w_result = w_a8 / w_b8;
        end
      end
    endcase
  end

  // Control FSM: grant in IDLE, compute in EXEC, hold the result in RESP until consumed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_last_grant <= ID_W'(NREQ - 1);
      r_gnt_id     <= '0;
      r_op         <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_resp_data  <= 8'h00;
      r_resp_id    <= '0;
      r_resp_err   <= 1'b0;
      r_resp_valid <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_any) begin
            r_op         <= w_grant_op;
            r_a          <= w_grant_a;
            r_b          <= w_grant_b;
            r_gnt_id     <= w_grant_idx;
            r_last_grant <= w_grant_idx;
            r_busy       <= 1'b1;
            r_state      <= EXEC;
          end
        end
        EXEC: begin
          r_resp_data  <= w_result;
          r_resp_id    <= r_gnt_id;
          r_resp_err   <= w_err;
          r_resp_valid <= 1'b1;
          r_state      <= RESP;
        end
        RESP: begin
          if (i_resp_ready) begin
            r_resp_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_state      <= IDLE;
          end
        end
        default: begin
          r_resp_valid <= 1'b0;
          r_busy       <= 1'b0;
          r_state      <= IDLE;
        end
      endcase
    end
  end

  assign o_resp_valid = r_resp_valid;
  assign o_resp_data  = r_resp_data;
  assign o_resp_id    = r_resp_id;
  assign o_resp_err   = r_resp_err;
  assign o_busy       = r_busy;

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Testbench for alu_req_scheduler: directed scenarios plus random traffic,
// checked cycle by cycle against a timeline model of the scheduler.
module tb_alu_req_scheduler;
  localparam int NREQ = 4;
  localparam int ID_W = 2;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [2*NREQ-1:0]   req_op;
  logic [3*NREQ-1:0]   req_a;
  logic [3*NREQ-1:0]   req_b;
  logic                resp_valid;
  logic                resp_ready;
  logic [7:0]          resp_data;
  logic [ID_W-1:0]     resp_id;
  logic                resp_err;
  logic                busy;

  always #5 clk = ~clk;

  alu_req_scheduler #(.NREQ(NREQ), .ID_W(ID_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_op     (req_op),
    .i_req_a      (req_a),
    .i_req_b      (req_b),
    .o_resp_valid (resp_valid),
    .i_resp_ready (resp_ready),
    .o_resp_data  (resp_data),
    .o_resp_id    (resp_id),
    .o_resp_err   (resp_err),
    .o_busy       (busy)
  );

  int checks   = 0;
  int failures = 0;

  // Model state: the in-flight request is described by the cycle number at
  // which it was accepted and by the result that the arithmetic rules predict.
  int   cyc        = 0;
  bit   m_pending  = 0;
  int   m_acc_cyc  = 0;
  int   m_last     = NREQ - 1;
  int   m_exp_data = 0;
  int   m_exp_id   = 0;
  int   m_exp_err  = 0;
  int   grant_q[$];
  int   grant_cyc_q[$];
  int   resp_count = 0;
  int   last_data  = 0;
  int   last_id    = 0;
  int   last_err   = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Result of one operation: {err, data}, computed with plain integer arithmetic.
  function automatic int alu_ref(input int op, input int a, input int b);
    int r;
    case (op)
      0: r = a + b;
      1: r = (a - b + 256) % 256;
      2: r = a * b;
      default: begin
        if (b == 0) begin
`ifdef ALU_REQ_SCHEDULER_DIVZ_EN
          r = 256 + 255;
`else
          r = 0;
`endif
        end else begin
          r = a / b;
        end
      end
    endcase
    return r;
  endfunction

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input int op, input int a, input int b);
    req_op[2*i +: 2] = 2'(op);
    req_a[3*i +: 3]  = 3'(a);
    req_b[3*i +: 3]  = 3'(b);
    req_valid[i]     = 1'b1;
  endtask

  // One clock cycle: check the outputs against the model on the falling edge,
  // advance the model, then let the rising edge happen.
  task automatic step();
    int pick;
    int exp_ready;
    int exp_rv;
    int exp_busy;
    int r;
    @(negedge clk);
    pick      = m_pending ? -1 : rr_pick(req_valid, m_last);
    exp_ready = (pick >= 0) ? (1 << pick) : 0;
    exp_rv    = (m_pending && cyc >= m_acc_cyc + 2) ? 1 : 0;
    exp_busy  = (m_pending && cyc > m_acc_cyc) ? 1 : 0;
    chk("req_ready", int'(req_ready), exp_ready);
    chk("resp_valid", int'(resp_valid), exp_rv);
    chk("busy", int'(busy), exp_busy);
    if (exp_rv == 1) begin
      chk("resp_data", int'(resp_data), m_exp_data);
      chk("resp_id", int'(resp_id), m_exp_id);
      chk("resp_err", int'(resp_err), m_exp_err);
      if (resp_ready) begin
        m_pending = 0;
        resp_count++;
        last_data = int'(resp_data);
        last_id   = int'(resp_id);
        last_err  = int'(resp_err);
        $display("txn id=%0d data=%02h err=%0d t=%0t", last_id, last_data, last_err, $time);
      end
    end
    if (pick >= 0) begin
      r = alu_ref(int'(req_op[2*pick +: 2]), int'(req_a[3*pick +: 3]), int'(req_b[3*pick +: 3]));
      m_pending  = 1;
      m_acc_cyc  = cyc;
      m_exp_data = r % 256;
      m_exp_err  = r / 256;
      m_exp_id   = pick;
      m_last     = pick;
      grant_q.push_back(pick);
      grant_cyc_q.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (pick >= 0) req_valid[pick] = 1'b0;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    req_valid  = '0;
    resp_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    cyc++;
    chk("rst_req_ready", int'(req_ready), 0);
    chk("rst_resp_valid", int'(resp_valid), 0);
    chk("rst_resp_data", int'(resp_data), 0);
    chk("rst_resp_id", int'(resp_id), 0);
    chk("rst_resp_err", int'(resp_err), 0);
    chk("rst_busy", int'(busy), 0);
    rst_n     = 1'b1;
    m_pending = 0;
    m_last    = NREQ - 1;
  endtask

  initial begin
    int n0;
    int nmin;
    rst_n      = 1'b0;
    req_valid  = '0;
    req_op     = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b0;
    do_reset();

    // Requester 0: add 3+4.
    resp_ready = 1'b1;
    n0 = resp_count;
    set_req(0, 0, 3, 4);
    repeat (4) step();
    chk("A_count", resp_count, n0 + 1);
    chk("A_data", last_data, 8'h07);
    chk("A_id", last_id, 0);

    // Requester 2: sub, mul, div in sequence.
    set_req(2, 1, 2, 5);
    repeat (4) step();
    chk("B_sub", last_data, 8'hFD);
    chk("B_sub_id", last_id, 2);
    set_req(2, 2, 7, 7);
    repeat (4) step();
    chk("B_mul", last_data, 8'h31);
    set_req(2, 3, 7, 2);
    repeat (4) step();
    chk("B_div", last_data, 8'h03);
    chk("B_div_id", last_id, 2);

    // All requesters continuously valid: rotating grants, one every 3 cycles.
    do_reset();
    grant_q.delete();
    grant_cyc_q.delete();
    resp_ready = 1'b1;
    repeat (18) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i]) set_req(i, int'($urandom_range(0, 3)), int'($urandom_range(0, 7)), int'($urandom_range(1, 7)));
      end
      step();
    end
    chk("C_grant_count", (grant_q.size() >= 6) ? 1 : 0, 1);
    nmin = (grant_q.size() < 6) ? grant_q.size() : 6;
    for (int k = 0; k < nmin; k++) chk("C_grant_order", grant_q[k], k % NREQ);
    for (int k = 1; k < nmin; k++) chk("C_interval", grant_cyc_q[k] - grant_cyc_q[k-1], 3);

    // Backpressure: result held for 10 cycles while another requester waits.
    do_reset();
    set_req(1, 2, 5, 6);
    set_req(3, 0, 1, 2);
    repeat (12) step();
    chk("D_hold_valid", int'(resp_valid), 1);
    chk("D_hold_data", int'(resp_data), 30);
    chk("D_hold_id", int'(resp_id), 1);
    chk("D_hold_busy", int'(busy), 1);
    chk("D_hold_ready", int'(req_ready), 0);
    resp_ready = 1'b1;
    repeat (6) step();
    chk("D_next_data", last_data, 3);
    chk("D_next_id", last_id, 3);

    // Divide by zero.
    set_req(0, 3, 5, 0);
    repeat (4) step();
`ifdef ALU_REQ_SCHEDULER_DIVZ_EN
    chk("E_divz_data", last_data, 8'hFF);
    chk("E_divz_err", last_err, 1);
`else
    chk("E_divz_data", last_data, 8'h00);
    chk("E_divz_err", last_err, 0);
`endif

    // Reset while the request from requester 2 is executing.
    n0 = resp_count;
    set_req(2, 0, 1, 1);
    step();
    chk("F_granted", grant_q[grant_q.size()-1], 2);
    do_reset();
    chk("F_no_resp", resp_count, n0);
    set_req(3, 0, 2, 2);
    set_req(0, 0, 1, 3);
    resp_ready = 1'b1;
    step();
    chk("F_first_after_rst", grant_q[grant_q.size()-1], 0);
    repeat (8) step();
    chk("F_drain", resp_count, n0 + 2);

    // Random traffic with random backpressure.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i]) begin
          if ($urandom_range(0, 2) == 0)
            set_req(i, int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                    ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 7)));
        end else if ($urandom_range(0, 15) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      resp_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    req_valid  = '0;
    resp_ready = 1'b1;
    repeat (5) step();
    chk("G_idle_end", int'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
